// File: rtl/red_pkg.sv
// Shared constants and helpers for the Barrett reduction pipeline.
// mod_ref is a plain-arithmetic golden reference for testbenches.
package red_pkg;

   localparam int unsigned Q_DILITHIUM = 8380417;
   localparam int unsigned W_DILITHIUM = 23;
   localparam int unsigned Q_KYBER     = 3329;
   localparam int unsigned W_KYBER     = 12;

   localparam int unsigned STAGES = 3;

   // floor(2^(2w) / q), evaluated at elaboration time.
   function automatic logic [63:0] barrett_mu(input int unsigned q, input int unsigned w);
      logic [63:0] num;
      num = 64'd1 << (2 * w);
      return num / 64'(q);
   endfunction

   function automatic logic [63:0] mod_ref(input logic [63:0] x, input logic [63:0] q);
      return x % q;
   endfunction

endpackage

// File: rtl/red_csub.sv
// One conditional subtraction of Q, narrowing the result to OW bits.
// Two of these in series bring a value in [0, 3Q) down to [0, Q).
module red_csub #(
   parameter int unsigned Q  = 8380417,
   parameter int unsigned IW = 25,
   parameter int unsigned OW = 24
) (
   input  logic [IW-1:0] a,
   output logic [OW-1:0] y
);

   localparam logic [IW-1:0] QI = IW'(Q);

   assign y = OW'((a >= QI) ? a - QI : a);

endmodule

// File: rtl/red_barrett_pipe.sv
// Three-stage Barrett reducer: 2W-bit product -> product mod Q, with
// valid/ready handshake, sideband tag and a global stall enable.
module red_barrett_pipe
   import red_pkg::*;
#(
   parameter int unsigned Q     = Q_DILITHIUM,
   parameter int unsigned W     = W_DILITHIUM,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2*W-1:0]   product_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [W-1:0]     result_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam int unsigned XW = 2 * W;
   localparam int unsigned RW = W + 2;
   localparam int unsigned TW = 2 * W + 3;

   localparam logic [63:0]   MU_FULL = barrett_mu(Q, W);
   localparam logic [RW-1:0] MU      = MU_FULL[RW-1:0];
   localparam logic [RW-1:0] QR      = RW'(Q);

   generate
      if (W != $clog2(Q)) begin : g_bad_w
         $error("red_barrett_pipe: W must equal $clog2(Q)");
      end
      if ((Q % 2) == 0) begin : g_bad_q
         $error("red_barrett_pipe: Q must be odd");
      end
      if (TAG_W < 1) begin : g_bad_tag
         $error("red_barrett_pipe: TAG_W must be at least 1");
      end
   endgenerate

   logic              en;
   logic [STAGES:1]   vld_pipe;

   logic [W:0]        xh;
   logic [RW-1:0]     qh_next;
   logic [RW-1:0]     x1, qh1;
   logic [TAG_W-1:0]  tag1;

   logic [RW-1:0]     r_next;
   logic [RW-1:0]     r2;
   logic [TAG_W-1:0]  tag2;

   logic [W:0]        c0;
   logic [W-1:0]      c1;
   logic [W-1:0]      res3;
   logic [TAG_W-1:0]  tag3;

   // Whole pipe advances unless the output holds a result nobody takes.
   assign en          = ~vld_pipe[STAGES] | out_ready_i;
   assign in_ready_o  = en;
   assign out_valid_o = vld_pipe[STAGES];
   assign result_o    = res3;
   assign tag_o       = tag3;

   // Only the low W+2 bits of x matter: r is formed modulo 2^(W+2).
   // The quotient estimate keeps t >> (W+1) directly instead of t.
   assign xh      = product_i[XW-1:W-1];
   assign qh_next = RW'((TW'(xh) * TW'(MU)) >> (W + 1));

   assign r_next  = x1 - qh1 * QR;

   red_csub #(.Q(Q), .IW(RW), .OW(W + 1)) u_csub0 (
      .a (r2),
      .y (c0)
   );

   red_csub #(.Q(Q), .IW(W + 1), .OW(W)) u_csub1 (
      .a (c0),
      .y (c1)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe <= '0;
         x1       <= '0;
         qh1      <= '0;
         tag1     <= '0;
         r2       <= '0;
         tag2     <= '0;
         res3     <= '0;
         tag3     <= '0;
      end else if (en) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_valid_i};
         x1       <= product_i[RW-1:0];
         qh1      <= qh_next;
         tag1     <= tag_i;
         r2       <= r_next;
         tag2     <= tag1;
         res3     <= c1;
         tag3     <= tag2;
      end
   end

endmodule

// File: tb/tb_red_barrett_pipe.sv
// Bench for red_barrett_pipe: directed boundary values, a Kyber instance,
// random streams with/without backpressure and a mid-flight reset.
module tb_red_barrett_pipe;
   import red_pkg::*;

   localparam int unsigned W  = W_DILITHIUM;
   localparam int unsigned Q  = Q_DILITHIUM;
   localparam int unsigned KW = W_KYBER;
   localparam int unsigned KQ = Q_KYBER;
   localparam int unsigned TG = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic            in_valid, in_ready, out_valid, out_ready;
   logic [2*W-1:0]  product;
   logic [TG-1:0]   tag, tag_out;
   logic [W-1:0]    result;

   logic            k_in_valid, k_in_ready, k_out_valid, k_out_ready;
   logic [2*KW-1:0] k_product;
   logic [TG-1:0]   k_tag, k_tag_out;
   logic [KW-1:0]   k_result;

   red_barrett_pipe #(.Q(Q), .W(W), .TAG_W(TG)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .product_i   (product),
      .tag_i       (tag),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .tag_o       (tag_out)
   );

   red_barrett_pipe #(.Q(KQ), .W(KW), .TAG_W(TG)) dut_kyber (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (k_in_valid),
      .in_ready_o  (k_in_ready),
      .product_i   (k_product),
      .tag_i       (k_tag),
      .out_valid_o (k_out_valid),
      .out_ready_i (k_out_ready),
      .result_o    (k_result),
      .tag_o       (k_tag_out)
   );

   int checks   = 0;
   int failures = 0;

   logic [63:0]   exp_q[$];
   logic [TG-1:0] tag_q[$];

   task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
      end
   endtask

   // Called at posedge+1. The operand is accepted at the next edge; the
   // result must be valid after the second edge following the accept.
   task automatic single(input string nm, input logic [63:0] x, input logic [TG-1:0] tg,
                         input logic [63:0] exp);
      product   = x[2*W-1:0];
      tag       = tg;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({nm, "_lat1"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check({nm, "_lat2"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check({nm, "_valid"}, 64'(out_valid), 64'd1);
      check({nm, "_result"}, 64'(result), exp);
      check({nm, "_tag"}, 64'(tag_out), 64'(tg));
      @(posedge clk); #1;
      check({nm, "_done"}, 64'(out_valid), 64'd0);
   endtask

   task automatic ksingle(input string nm, input logic [63:0] x, input logic [TG-1:0] tg,
                          input logic [63:0] exp);
      k_product   = x[2*KW-1:0];
      k_tag       = tg;
      k_in_valid  = 1'b1;
      k_out_ready = 1'b1;
      @(posedge clk); #1;
      k_in_valid = 1'b0;
      @(posedge clk); #1;
      check({nm, "_lat"}, 64'(k_out_valid), 64'd0);
      @(posedge clk); #1;
      check({nm, "_valid"}, 64'(k_out_valid), 64'd1);
      check({nm, "_result"}, 64'(k_result), exp);
      check({nm, "_tag"}, 64'(k_tag_out), 64'(tg));
   endtask

   // Streams n random operands; bp randomises out_ready, gaps inserts input bubbles.
   task automatic stream(input int n, input bit bp, input bit gaps);
      int            sent = 0;
      int            got  = 0;
      int            cyc  = 0;
      bit            have = 0;
      bit            prev_stall = 0;
      logic [63:0]   rv;
      logic [2*W-1:0] cur = '0;
      logic [TG-1:0] ctag = '0;
      logic [W-1:0]  prev_res = '0;
      logic [TG-1:0] prev_tag = '0;
      while ((sent < n || exp_q.size() > 0) && cyc < n * 6 + 100) begin
         if (!have && sent < n && (!gaps || $urandom_range(3) != 0)) begin
            rv   = {$urandom(), $urandom()};
            cur  = rv[2*W-1:0];
            ctag = sent[TG-1:0];
            have = 1;
         end
         in_valid  = have;
         product   = cur;
         tag       = ctag;
         out_ready = bp ? 1'($urandom_range(1)) : 1'b1;
         #1;
         check("ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
         if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_result", 64'(result), 64'(prev_res));
            check("stall_tag", 64'(tag_out), 64'(prev_tag));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               check("stream_result", 64'(result), exp_q.pop_front());
               check("stream_tag", 64'(tag_out), 64'(tag_q.pop_front()));
            end
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = result;
         prev_tag   = tag_out;
         if (in_valid && in_ready) begin
            exp_q.push_back(mod_ref(64'(cur), 64'(Q)));
            tag_q.push_back(ctag);
            sent++;
            have = 0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("stream_drained", 64'(exp_q.size()), 64'd0);
      check("stream_count", 64'(got), 64'(n));
   endtask

   initial begin
      logic [63:0] rv;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      product     = '0;
      tag         = '0;
      out_ready   = 1'b1;
      k_in_valid  = 1'b0;
      k_product   = '0;
      k_tag       = '0;
      k_out_ready = 1'b1;
      #2;
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_result", 64'(result), 64'd0);
      check("reset_tag", 64'(tag_out), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_ready", 64'(in_ready), 64'd1);

      single("d838041", 64'd838041, 4'd1, 64'd838041);
      single("d8380418", 64'd8380418, 4'd2, 64'd1);
      single("d96745219", 64'd96745219, 4'd3, 64'd4560632);
      single("zero", 64'd0, 4'd4, 64'd0);
      single("q_minus_1", 64'd8380416, 4'd5, 64'd8380416);
      single("q", 64'd8380417, 4'd6, 64'd0);
      single("max", (64'd1 << 46) - 64'd1, 4'd7, 64'd49144);

      ksingle("k_sq", 64'd11075584, 4'd1, 64'd1);
      ksingle("k_q", 64'd3329, 4'd2, 64'd0);
      ksingle("k_max", 64'hFF_FFFF, 4'd3, mod_ref(64'hFF_FFFF, 64'(KQ)));

      stream(100, 1'b0, 1'b0);
      stream(150, 1'b1, 1'b1);

      // Three operands in flight, then an asynchronous reset.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rv      = {$urandom(), $urandom()};
         product = rv[2*W-1:0];
         tag     = TG'(i + 8);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      check("midrst_tag", 64'(tag_out), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("midrst_quiet", 64'(out_valid), 64'd0);
         check("midrst_ready", 64'(in_ready), 64'd1);
         @(posedge clk); #1;
      end
      single("after_rst", 64'd12345678901, 4'd9, mod_ref(64'd12345678901, 64'(Q)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
